bitlet_aligner: RTL and testbench

Pipelined exponent-alignment stage of the Bitlet PE preprocessor, directly downstream of the reassembler array. Takes one vector of N_input (Esum, Afix) pairs per transaction. Finds the maximum Esum, arithmetically right-shifts every Afix by its distance from that maximum into a guard-extended fixed-point word, and hands the aligned vector plus Emax to the Bitlet distiller under valid/ready flow control.

---
 rtl/bitlet_aligner_pkg.sv | 12 +
 rtl/bitlet_aligner_maxtree.sv | 29 ++
 rtl/bitlet_aligner.sv | 101 ++++++++++
 tb/tb_bitlet_aligner.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bitlet_aligner_pkg.sv
// Shared widths for the Bitlet exponent-alignment stage.
// Exponent-sum and fixed-point mantissa widths match the reassembler array outputs.
package bitlet_aligner_pkg;

  localparam int WID_EXS = 8;
  localparam int WID_FIX = 12;

  function automatic int widAln(input int wExt);
    return WID_FIX + wExt;
  endfunction

endpackage

// File: rtl/bitlet_aligner_maxtree.sv
// Bitlet_MaxTree: combinational balanced max tree over N_input unsigned exponent sums.
// Lanes are padded to a power of two with zeros, which never win against a real lane.
module Bitlet_MaxTree #(
  parameter int N_input = 16,
  parameter int Wid_exs = 8
) (
  input  logic [N_input*Wid_exs-1:0] esum_i,
  output logic [Wid_exs-1:0]         max_o
);

  localparam int LEVELS = (N_input > 1) ? $clog2(N_input) : 0;
  localparam int P      = 1 << LEVELS;

  logic [Wid_exs-1:0] nodes [P];

  // Each pass halves the active width in place; lower indices are written before higher ones are read.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      nodes[i] = (i < N_input) ? esum_i[i*Wid_exs +: Wid_exs] : '0;
    end
    for (int w = P / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        nodes[i] = (nodes[2*i] >= nodes[2*i+1]) ? nodes[2*i] : nodes[2*i+1];
      end
    end
    max_o = nodes[0];
  end

endmodule

// File: rtl/bitlet_aligner.sv
// bitlet_aligner: two-stage exponent alignment (S1: max + shift amounts, S2: per-lane arithmetic shift).
// Optional BITLET_ALIGN_STICKY_EN folds shifted-out bits into each lane's LSB.
module bitlet_aligner
  import bitlet_aligner_pkg::*;
#(
  parameter int N_input = 16,
  parameter int W_ext   = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [N_input*WID_EXS-1:0]            Esum_vec,
  input  logic [N_input*WID_FIX-1:0]            Afix_vec,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WID_EXS-1:0]                    Emax,
  output logic [N_input*widAln(W_ext)-1:0]      Aaln_vec
);

  localparam int WID_ALN = widAln(W_ext);
  localparam int SHW     = $clog2(WID_ALN);

  logic                         v1_q, v2_q;
  logic                         adv1, adv2;
  logic [WID_EXS-1:0]           emaxTree;
  logic [WID_EXS-1:0]           emax1_q, emax2_q;
  logic [N_input*WID_FIX-1:0]   afix1_q;
  logic [N_input*WID_EXS-1:0]   sh_d, sh1_q;
  logic [N_input*WID_ALN-1:0]   aaln_d, aaln2_q;

  assign adv2      = !v2_q || out_ready;
  assign adv1      = !v1_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2_q;
  assign Emax      = emax2_q;
  assign Aaln_vec  = aaln2_q;

  Bitlet_MaxTree #(
    .N_input (N_input),
    .Wid_exs (WID_EXS)
  ) uMaxTree (
    .esum_i (Esum_vec),
    .max_o  (emaxTree)
  );

  for (genvar i = 0; i < N_input; i++) begin : gShift
    assign sh_d[i*WID_EXS +: WID_EXS] = emaxTree - Esum_vec[i*WID_EXS +: WID_EXS];
  end

  for (genvar i = 0; i < N_input; i++) begin : gLane
    logic signed [WID_ALN-1:0] ext;
    logic signed [WID_ALN-1:0] shifted;
    logic [WID_EXS-1:0]        sh;
    logic [SHW-1:0]            shAmt;

    assign sh  = sh1_q[i*WID_EXS +: WID_EXS];
    assign ext = {afix1_q[i*WID_FIX +: WID_FIX], {W_ext{1'b0}}};
    // Clamping to WID_ALN-1 yields all sign bits, so oversize shifts cannot wrap.
    assign shAmt   = (32'(sh) >= 32'(WID_ALN)) ? SHW'(WID_ALN - 1) : SHW'(sh);
    assign shifted = ext >>> shAmt;

`ifdef BITLET_ALIGN_STICKY_EN
    logic sticky;
    assign sticky = |(ext & ~({WID_ALN{1'b1}} << shAmt));
    assign aaln_d[i*WID_ALN +: WID_ALN] = {shifted[WID_ALN-1:1], shifted[0] | sticky};
`else
    assign aaln_d[i*WID_ALN +: WID_ALN] = shifted;
`endif
  end

  // Each stage loads only when it may advance, so a stalled output holds its data and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      emax1_q <= '0;
      emax2_q <= '0;
      afix1_q <= '0;
      sh1_q   <= '0;
      aaln2_q <= '0;
    end else begin
      if (adv1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          emax1_q <= emaxTree;
          afix1_q <= Afix_vec;
          sh1_q   <= sh_d;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          emax2_q <= emax1_q;
          aaln2_q <= aaln_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitlet_aligner.sv
// Directed bench for bitlet_aligner with N_input=4, W_ext=4 (16-bit aligned lanes).
// Build with +define+BITLET_ALIGN_STICKY_EN to check the sticky variant.
module tb_bitlet_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Esum_vec;
  logic [47:0] Afix_vec;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  Emax;
  logic [63:0] Aaln_vec;

  int errors = 0;
  int checks = 0;

`ifdef BITLET_ALIGN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  always #5 clk = ~clk;

  bitlet_aligner #(
    .N_input (4),
    .W_ext   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Esum_vec  (Esum_vec),
    .Afix_vec  (Afix_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Emax      (Emax),
    .Aaln_vec  (Aaln_vec)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] e, input logic [47:0] a);
    @(negedge clk);
    Esum_vec = e;
    Afix_vec = a;
    in_valid = 1'b1;
    #1;
    checkOutput("drive_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic runVector(input string tag, input logic [31:0] e, input logic [47:0] a,
                           input logic [7:0] expEmax, input logic [63:0] expAaln);
    applyStimulus(e, a);
    checkOutput({tag, "_lat1_valid"}, out_valid, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, out_valid, 1'b1);
    checkOutput({tag, "_emax"}, Emax, expEmax);
    checkOutput({tag, "_aaln"}, Aaln_vec, expAaln);
  endtask

  logic [31:0] bpE [6];
  logic [47:0] bpA [6];
  logic [7:0]  expE [6];
  logic [63:0] expA [6];
  bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int sent, recvd, cyc;
    bit mv1, mv2, adv1m, adv2m, holdPrev;
    logic [63:0] prevA;
    logic [7:0]  prevE;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    Esum_vec  = $urandom;
    Afix_vec  = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_emax", Emax, 8'd0);
    checkOutput("rst_aaln", Aaln_vec, 64'd0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    runVector("mixed", 32'h03080A0A, 48'h005_010_FF0_010, 8'd10,
              {15'd0, STICKY, 16'h0040, 16'hFF00, 16'h0100});
    runVector("equal", 32'h07070707, 48'hFFF_FFF_FFF_FFF, 8'd7, 64'hFFF0_FFF0_FFF0_FFF0);
    runVector("spread255", 32'h000000FF, 48'h000_003_FFD_001, 8'd255,
              {16'h0000, 15'd0, STICKY, 16'hFFFF, 16'h0010});
    runVector("spread16", 32'h00000010, 48'h000_003_FFD_001, 8'd16,
              {16'h0000, 15'd0, STICKY, 16'hFFFF, 16'h0010});

    for (int k = 0; k < 6; k++) begin
      bpE[k]  = {4{8'(k + 1)}};
      expE[k] = 8'(k + 1);
      for (int l = 0; l < 4; l++) begin
        bpA[k][l*12 +: 12]  = 12'(k * 4 + l + 1);
        expA[k][l*16 +: 16] = 16'((k * 4 + l + 1) * 16);
      end
    end
    sent = 0; recvd = 0; cyc = 0;
    mv1 = 1'b0; mv2 = 1'b0; holdPrev = 1'b0;
    prevA = '0; prevE = '0;
    while (recvd < 6 && cyc < 80) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      if (sent < 6) begin
        in_valid = 1'b1;
        Esum_vec = bpE[sent];
        Afix_vec = bpA[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checkOutput("bp_in_ready", in_ready, !(mv1 && mv2 && !out_ready));
      checkOutput("bp_out_valid", out_valid, mv2);
      if (holdPrev) begin
        checkOutput("bp_hold_aaln", Aaln_vec, prevA);
        checkOutput("bp_hold_emax", Emax, prevE);
      end
      if (out_valid && out_ready) begin
        checkOutput("bp_emax", Emax, expE[recvd]);
        checkOutput("bp_aaln", Aaln_vec, expA[recvd]);
        recvd++;
      end
      holdPrev = out_valid && !out_ready;
      prevA    = Aaln_vec;
      prevE    = Emax;
      adv2m    = !mv2 || out_ready;
      adv1m    = !mv1 || adv2m;
      if (in_valid && adv1m) sent++;
      if (adv2m) mv2 = mv1;
      if (adv1m) mv1 = in_valid;
      cyc++;
    end
    checkOutput("bp_received", 64'(recvd), 64'd6);

    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    Esum_vec  = 32'h01010101;
    Afix_vec  = 48'h001_001_001_001;
    @(negedge clk);
    Afix_vec  = 48'h002_002_002_002;
    @(negedge clk);
    in_valid  = 1'b0;
    #1;
    checkOutput("full_out_valid", out_valid, 1'b1);
    checkOutput("full_in_ready", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 1'b0);
    checkOutput("midrst_aaln", Aaln_vec, 64'd0);
    checkOutput("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("post_rst_valid", out_valid, 1'b0);
    runVector("postrst", 32'h07070707, 48'hFFF_FFF_FFF_FFF, 8'd7, 64'hFFF0_FFF0_FFF0_FFF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
